// File: rtl/training_sequencer_pkg.sv
// training_sequencer_pkg
//   Constants and types shared by the training-set streamer and the
//   downstream marker-stripping / iteration-counting stage.
//   - DEFAULT_MARKER : end-of-sample marker word
//   - DEFAULT_EPOCHS : number of passes over the training set
//   - state_t        : streamer FSM state encoding
package training_sequencer_pkg;

  localparam int DEFAULT_MARKER = 342;
  localparam int DEFAULT_EPOCHS = 10000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_MARK  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/training_sequencer.sv
// training_sequencer
//   Streams the training set out of a synchronous sample ROM, one word per
//   valid/ready handshake. After each sample it emits the marker word, and it
//   repeats the whole set for EPOCHS passes before raising done.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, starts a run from IDLE or DONE
//   rd_en        ROM read strobe (high only in READ)
//   rd_addr      ROM word address
//   rd_data      ROM data, valid the cycle after rd_en
//   data_out     stream word (MARKER while in MARK)
//   data_valid   data_out valid (SEND or MARK)
//   data_ready   downstream accepts the word
//   busy         run in progress
//   done         all epochs streamed, held until start or reset
//   epoch_count  completed epochs
//   collision    sticky: a ROM word equal to MARKER was seen
module training_sequencer
  import training_sequencer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SAMPLE_LEN  = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int EPOCHS      = DEFAULT_EPOCHS,
  parameter int MARKER      = DEFAULT_MARKER,
  parameter int ADDR_W      = (SAMPLE_LEN * NUM_SAMPLES > 1) ?
                              $clog2(SAMPLE_LEN * NUM_SAMPLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] epoch_count,
  output logic              collision
);

  localparam int WORD_W = (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1;
  localparam int SAMP_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(SAMPLE_LEN - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(NUM_SAMPLES - 1);
  localparam logic [DATA_W-1:0] EPOCHS_V   = DATA_W'(EPOCHS);
  localparam logic [DATA_W-1:0] MARKER_V   = DATA_W'(MARKER);
  // A data word that would look like the marker is nudged down by one so
  // the downstream stage never sees a false end-of-sample.
  localparam logic [DATA_W-1:0] MARKER_ALT = DATA_W'(MARKER - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic [DATA_W-1:0]   epoch_q, epoch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                collision_q, collision_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      samp_q      <= '0;
      epoch_q     <= '0;
      data_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      samp_q      <= samp_d;
      epoch_q     <= epoch_d;
      data_q      <= data_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    samp_d      = samp_q;
    epoch_d     = epoch_q;
    data_d      = data_q;
    collision_d = collision_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d      = '0;
          word_d      = '0;
          samp_d      = '0;
          epoch_d     = '0;
          collision_d = 1'b0;
          state_d     = ST_READ;
        end
      end

      ST_READ: state_d = ST_LATCH;

      ST_LATCH: begin
        if (rd_data == MARKER_V) begin
          data_d      = MARKER_ALT;
          collision_d = 1'b1;
        end else begin
          data_d = rd_data;
        end
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (data_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          if (word_q != WORD_LAST) begin
            word_d  = word_q + WORD_W'(1);
            state_d = ST_READ;
          end else begin
            word_d  = '0;
            state_d = ST_MARK;
          end
        end
      end

      ST_MARK: begin
        if (data_ready) begin
          if (samp_q != SAMP_LAST) begin
            samp_d  = samp_q + SAMP_W'(1);
            state_d = ST_READ;
          end else begin
            // End of epoch: rewind to the first sample.
            samp_d  = '0;
            addr_d  = '0;
            epoch_d = epoch_q + DATA_W'(1);
            state_d = (epoch_d == EPOCHS_V) ? ST_DONE : ST_READ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are the registers themselves or decodes of the state register.
  assign rd_en       = (state_q == ST_READ);
  assign rd_addr     = addr_q;
  assign data_valid  = (state_q == ST_SEND) || (state_q == ST_MARK);
  assign data_out    = (state_q == ST_MARK) ? MARKER_V : data_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign epoch_count = epoch_q;
  assign collision   = collision_q;

endmodule

// File: doc/training_sequencer.md
# training_sequencer

Streams the autoencoder training set from a synchronous sample ROM into the marker-counting memory stage, one 16-bit word per valid/ready handshake. It inserts the end-of-sample marker word (342) after every sample and repeats the full data set for a fixed number of epochs. It then raises `done`. It sits directly upstream of the stage that strips the marker and counts training iterations.

## Interface
- `DATA_W`, 16, width of data words and of the epoch counter.
- `SAMPLE_LEN`, 8, data words per sample (≥1).
- `NUM_SAMPLES`, 4, samples per epoch (≥1).
- `EPOCHS`, 10000, epochs to stream before `done` (1..2^DATA_W−1).
- `MARKER`, 16'd342, end-of-sample marker value.
- `ADDR_W`, clog2(SAMPLE_LEN·NUM_SAMPLES), ROM address width (≥1).
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- `rd_en`  out  1  ROM read strobe.
- `rd_addr`  out  ADDR_W  ROM word address.
- `rd_data`  in  DATA_W  ROM data, valid the cycle after `rd_en`.
- `data_out`  out  DATA_W  stream word.
- `data_valid`  out  1  `data_out` valid.
- `data_ready`  in  1  downstream accepts the word.
- `busy`  out  1  run in progress (not IDLE/DONE).
- `done`  out  1  all epochs streamed; held until `start` or reset.
- `epoch_count`  out  DATA_W  completed epochs.
- `collision`  out  1  sticky; a ROM word equal to MARKER was seen.

## Operation
- FSM states:
  - IDLE: wait for a run.
  - READ: `rd_en`=1, `rd_addr`=addr register.
  - LATCH: load `data_out` ← `rd_data`.
  - SEND: `data_valid`=1.
  - MARK: `data_valid`=1, `data_out`=MARKER.
  - DONE: `done`=1.
- Transitions:
  - IDLE or DONE with `start` → READ. Clears addr, word index, sample index, `epoch_count`, `done` and `collision`.
  - READ → LATCH unconditionally.
  - LATCH → SEND unconditionally.
  - SEND with handshake (`data_valid`&`data_ready`): addr+1. If word index < SAMPLE_LEN−1, then word index+1 → READ. Otherwise word index ← 0 → MARK.
  - MARK with handshake: if sample index < NUM_SAMPLES−1, then sample index+1 → READ.
  - Otherwise MARK with handshake ends the epoch: sample index ← 0, addr ← 0, `epoch_count`+1. It then goes → DONE if the new count equals EPOCHS, else → READ.
- No handshake in SEND or MARK: state, `data_out` and `data_valid` are held stable.
- Marker collision: a ROM word equal to MARKER is emitted as MARKER−1 and sets `collision`. Downstream never sees MARKER inside a sample.
- `start` while busy is ignored.
- `rd_en` is low in every state except READ.
- Reset, in any state (including mid-sample or mid-handshake):
  - returns the FSM to IDLE immediately;
  - clears all counters and outputs;
  - the partial stream is abandoned and not resumed.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, `epoch_count`=0, `collision`=0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- `start` sampled high at edge N → READ during cycle N+1 → first `data_valid` during cycle N+3.
- Data word throughput: one word per 3 cycles minimum (READ, LATCH, SEND with `data_ready` high).
- Marker: occupies 1 cycle minimum, immediately after the last data word of the sample is accepted.
- Final marker accepted at edge M:
  - `epoch_count` reaches EPOCHS at edge M;
  - `done`=1 and `busy`=0 from cycle M+1.
- Minimum cycles per epoch: NUM_SAMPLES·(3·SAMPLE_LEN+1).

## Structure
- Shared package holds:
  - the default MARKER (342) and the default EPOCHS (10000), shared with the downstream counter stage;
  - the FSM state encoding.
- Single module, with no sub-modules. Three counters (word index, sample index, epoch) sit inline in the FSM always block.

## Test plan
- Parameters for short runs: SAMPLE_LEN=3, NUM_SAMPLES=2, EPOCHS=2, ROM[i]=i+1, `data_ready` tied high.
  - Pulse `start` → accepted words are 1,2,3,342,4,5,6,342,1,2,3,342,4,5,6,342.
  - `epoch_count` goes 0→1→2.
  - `done`=1 the cycle after the 16th handshake.
  - First `data_valid` appears 3 cycles after `start`.
- Backpressure: hold `data_ready` low for 5 cycles while in SEND with word 2 → `data_out`=2 and `data_valid`=1 stay stable and `rd_en` stays 0. The stream resumes with no loss or duplication.
- Collision: ROM[1]=342 → the second word is emitted as 341 and `collision`=1, held until the next `start`.
- Assert `rst` mid-run (in MARK) → all outputs are 0 within the same cycle. A fresh `start` then restarts from address 0 with `epoch_count`=0.
- Pulse `start` while busy → no effect on sequence or counters. Pulse `start` in DONE → a new run begins and `done` clears.
